// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register-file dump engine:
// architectural sizes and the dumper state encoding.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND0,
        SEND1,
        DONE
    } dump_state_e;

endpackage

// File: rtl/mips_register_dumper.sv
// Walks a contiguous, wrapping range of registers through the two register
// file read ports and streams the captured values over valid/ready.
module mips_register_dumper
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = mips_pkg::REG_DATA_W,
    parameter int ADDR_WIDTH = mips_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = mips_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dump_base,
    input  logic [ADDR_WIDTH:0]   dump_count,
    output logic [ADDR_WIDTH-1:0] read_reg_1,
    output logic [ADDR_WIDTH-1:0] read_reg_2,
    input  logic [DATA_WIDTH-1:0] read_data_1,
    input  logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

    function automatic logic [ADDR_WIDTH-1:0] wrapInc(input logic [ADDR_WIDTH-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_ONE;
    endfunction

    dump_state_e           state_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic [ADDR_WIDTH-1:0] rdAddr1_q;
    logic [ADDR_WIDTH-1:0] rdAddr2_q;
    logic [DATA_WIDTH-1:0] buf0_q;
    logic [DATA_WIDTH-1:0] buf1_q;
    logic [ADDR_WIDTH-1:0] idxInc_d;
    logic                  lastBeat_d;

    assign idxInc_d   = wrapInc(idx_q);
    assign lastBeat_d = (rem_q == REM_ONE);

    // Read addresses are loaded on entry to FETCH so they are stable for the whole capture cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rem_q     <= '0;
            rdAddr1_q <= '0;
            rdAddr2_q <= '0;
            buf0_q    <= '0;
            buf1_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (dump_count != REM_ZERO) begin
                            idx_q     <= dump_base;
                            rem_q     <= dump_count;
                            rdAddr1_q <= dump_base;
                            rdAddr2_q <= wrapInc(dump_base);
                            state_q   <= FETCH;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                FETCH: begin
                    buf0_q  <= read_data_1;
                    buf1_q  <= read_data_2;
                    state_q <= SEND0;
                end
                SEND0: begin
                    if (out_ready) begin
                        rem_q   <= rem_q - REM_ONE;
                        idx_q   <= idxInc_d;
                        state_q <= lastBeat_d ? DONE : SEND1;
                    end
                end
                SEND1: begin
                    if (out_ready) begin
                        rem_q <= rem_q - REM_ONE;
                        idx_q <= idxInc_d;
                        if (lastBeat_d) begin
                            state_q <= DONE;
                        end else begin
                            rdAddr1_q <= idxInc_d;
                            rdAddr2_q <= wrapInc(idxInc_d);
                            state_q   <= FETCH;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode flop state only, so out_valid never depends on out_ready.
    always_comb begin
        out_valid = (state_q == SEND0) || (state_q == SEND1);
        out_data  = '0;
        if (state_q == SEND0) out_data = buf0_q;
        if (state_q == SEND1) out_data = buf1_q;
        out_index = out_valid ? idx_q : '0;
        out_last  = out_valid && lastBeat_d;
        busy      = (state_q == FETCH) || out_valid;
        done      = (state_q == DONE);
    end

    assign read_reg_1 = rdAddr1_q;
    assign read_reg_2 = rdAddr2_q;

endmodule
